// File: rtl/dsp_fetch.sv
// dsp_fetch: instruction fetch stage of the DSP core.
// Owns the program counter, issues reads to a 1-cycle synchronous
// instruction memory, and buffers returned words in a small prefetch FIFO
// that feeds decode over a valid/ready handshake. A redirect from the
// branch unit reloads the PC and flushes everything already fetched.
module dsp_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               jump_flag,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);

  // Occupancy counts 0..DEPTH; one extra bit lets occupancy + inflight
  // be formed without overflow before the credit comparison.
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] tag_reg;
  logic              inflight_reg;
  logic              squash_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  wr_idx;
  logic [CNT_W:0]    credit_use;
  logic              pop;
  logic              push;

  // Shift-register FIFO: entry 0 is always the head presented to decode.
  logic [DEPTH-1:0][INSTR_W-1:0] data_reg;
  logic [DEPTH-1:0][INSTR_W-1:0] data_next;
  logic [DEPTH-1:0][ADDR_W-1:0]  addr_reg;
  logic [DEPTH-1:0][ADDR_W-1:0]  addr_next;

  assign instr_valid = (count_reg != '0);
  assign instr       = data_reg[0];
  assign instr_pc    = addr_reg[0];
  assign pop         = instr_valid & instr_ready;

  // A slot is reserved for every outstanding read, so a request only goes
  // out when the FIFO is certain to have room for its response. The pop of
  // this cycle frees a slot early, which sustains one word per cycle.
  assign credit_use = {1'b0, count_reg}
                    + (CNT_W + 1)'(inflight_reg)
                    - (CNT_W + 1)'(pop);
  assign imem_en    = rst_n & ~jump_flag & ~halt
                    & (credit_use < (CNT_W + 1)'(DEPTH));
  assign imem_addr  = pc_reg;

  // A redirect in the same cycle discards the returning word outright.
  assign push   = inflight_reg & ~squash_reg & ~jump_flag;
  // With a simultaneous pop the new word lands one slot lower, after the shift.
  assign wr_idx = count_reg - CNT_W'(pop);

  // Next occupancy: flush wins over any push or pop.
  always_comb begin
    count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    if (jump_flag) begin
      count_next = '0;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic               sel_push;
    logic               sel_shift;
    logic [INSTR_W-1:0] shift_data;
    logic [ADDR_W-1:0]  shift_addr;

    // Only occupied entries behind the head move up on a pop, so a lone
    // head entry keeps its value once the FIFO drains empty.
    assign sel_push  = push & (CNT_W'(gi) == wr_idx);
    assign sel_shift = pop & (CNT_W'(gi + 1) < count_reg);

    if (gi < DEPTH - 1) begin : g_shift
      assign shift_data = data_reg[gi + 1];
      assign shift_addr = addr_reg[gi + 1];
    end else begin : g_last
      assign shift_data = data_reg[gi];
      assign shift_addr = addr_reg[gi];
    end

    assign data_next[gi] = jump_flag ? data_reg[gi] :
                           sel_push  ? imem_rdata   :
                           sel_shift ? shift_data   : data_reg[gi];
    assign addr_next[gi] = jump_flag ? addr_reg[gi] :
                           sel_push  ? tag_reg      :
                           sel_shift ? shift_addr   : addr_reg[gi];
  end

  // FIFO storage update; contents are cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      addr_reg <= '0;
    end else begin
      data_reg <= data_next;
      addr_reg <= addr_next;
    end
  end

  // PC, outstanding-read tracking and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= RESET_PC;
      tag_reg      <= '0;
      inflight_reg <= 1'b0;
      squash_reg   <= 1'b0;
      count_reg    <= '0;
    end else begin
      count_reg    <= count_next;
      inflight_reg <= imem_en;
      squash_reg   <= jump_flag & inflight_reg;
      if (imem_en) begin
        tag_reg <= pc_reg;
      end
      if (jump_flag) begin
        pc_reg <= jump_addr;
      end else if (imem_en) begin
        pc_reg <= pc_reg + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dsp_fetch.sv
// Testbench for dsp_fetch: a queue-based reference model checked every
// cycle, directed literal expectations along the scenario, and a second
// instance with RESET_PC=0xFFFE to exercise PC wrap-around.
module tb_dsp_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_flag;
  logic [15:0] jump_addr;
  logic        halt;
  logic        instr_ready;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;

  logic        tie0 = 1'b0;
  logic        tie1 = 1'b1;
  logic [15:0] tie_addr = '0;
  logic        imem_en1;
  logic [15:0] imem_addr1;
  logic [15:0] imem_rdata1 = '0;
  logic        instr_valid1;
  logic [15:0] instr1;
  logic [15:0] instr_pc1;

  int total = 0;
  int bad   = 0;

  // reference model state: fetched-but-undelivered addresses, PC, pending read
  logic [15:0] q[$];
  logic [15:0] m_pc;
  int          pend;
  logic [15:0] pend_addr;

  logic [15:0] cap_pc[$];
  logic [15:0] cap_d[$];

  always #5 clk = ~clk;

  dsp_fetch #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .jump_flag(jump_flag), .jump_addr(jump_addr),
    .halt(halt), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  dsp_fetch #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .jump_flag(tie0), .jump_addr(tie_addr),
    .halt(tie0), .imem_en(imem_en1), .imem_addr(imem_addr1),
    .imem_rdata(imem_rdata1), .instr_valid(instr_valid1),
    .instr_ready(tie1), .instr(instr1), .instr_pc(instr_pc1)
  );

  function automatic logic [15:0] memf(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  // instruction memories: word[i] = 0x1000 + i, one cycle read latency
  initial forever begin
    @(posedge clk);
    if (imem_en)  imem_rdata  <= memf(imem_addr);
    if (imem_en1) imem_rdata1 <= memf(imem_addr1);
  end

  // model update at each active edge from the inputs sampled there
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_pc = 16'h0000;
      pend = 0;
    end else begin
      int occ;
      bit pop_e;
      bit en_e;
      occ   = q.size();
      pop_e = (occ > 0) && instr_ready;
      en_e  = !jump_flag && !halt && (occ + pend - int'(pop_e) < DEPTH);
      if (jump_flag) begin
        q.delete();
        pend = 0;
        m_pc = jump_addr;
      end else begin
        if (pop_e) void'(q.pop_front());
        if (pend != 0) q.push_back(pend_addr);
        pend = en_e ? 1 : 0;
        if (en_e) begin
          pend_addr = m_pc;
          m_pc      = m_pc + 16'h1;
        end
      end
    end
  end

  // compare DUT outputs against the model every cycle, mid-cycle
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      m_pc = 16'h0000;
      pend = 0;
      check("rst_imem_en", imem_en, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_instr", instr, 0);
      check("rst_instr_pc", instr_pc, 0);
    end else begin
      int occ;
      bit pop_e;
      bit en_e;
      occ   = q.size();
      pop_e = (occ > 0) && instr_ready;
      en_e  = !jump_flag && !halt && (occ + pend - int'(pop_e) < DEPTH);
      check("valid", instr_valid, (occ > 0) ? 1 : 0);
      if (occ > 0) begin
        check("instr_pc", instr_pc, q[0]);
        check("instr", instr, memf(q[0]));
      end
      check("imem_en", imem_en, en_e ? 1 : 0);
      if (en_e) check("imem_addr", imem_addr, m_pc);
      if (pop_e) $display("deliver pc=%04h instr=%04h", instr_pc, instr);
    end
  end

  // capture the first four words delivered by the wrap-around instance
  initial forever begin
    @(negedge clk);
    if (rst_n && instr_valid1 && cap_pc.size() < 4) begin
      cap_pc.push_back(instr_pc1);
      cap_d.push_back(instr1);
    end
  end

  initial begin
    logic [15:0] exp_pc1 [4];
    logic [15:0] exp_d1  [4];
    exp_pc1 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_d1  = '{16'h0FFE, 16'h0FFF, 16'h1000, 16'h1001};

    rst_n = 1'b0; jump_flag = 1'b0; jump_addr = '0; halt = 1'b0; instr_ready = 1'b1;
    repeat (2) to_pos();
    to_neg();
    check("lit_rst_en", imem_en, 0);
    check("lit_rst_valid", instr_valid, 0);

    // reset release and streaming
    to_pos(); rst_n = 1'b1;
    to_neg(); check("lit_c1_en", imem_en, 1); check("lit_c1_addr", imem_addr, 16'h0000);
    to_pos(); to_neg(); check("lit_c2_addr", imem_addr, 16'h0001);
    to_pos(); to_neg();
    check("lit_c3_valid", instr_valid, 1);
    check("lit_c3_pc", instr_pc, 16'h0000);
    check("lit_c3_instr", instr, 16'h1000);
    to_pos(); to_neg(); check("lit_c4_instr", instr, 16'h1001);

    // decode stall for five cycles
    repeat (5) to_pos();
    instr_ready = 1'b0;
    to_neg(); check("lit_stall_en", imem_en, 0); check("lit_stall_pc", instr_pc, 16'h0006);
    to_pos(); to_pos();
    to_neg(); check("lit_stall3_en", imem_en, 0); check("lit_stall3_pc", instr_pc, 16'h0006);
    repeat (3) to_pos();
    instr_ready = 1'b1;
    to_neg(); check("lit_resume_addr", imem_addr, 16'h0008); check("lit_resume_en", imem_en, 1);
    to_pos(); to_pos();
    to_neg(); check("lit_resume_pc", instr_pc, 16'h0008);

    // jump with a word buffered and a read in flight
    repeat (3) to_pos();
    jump_flag = 1'b1; jump_addr = 16'h0040;
    to_neg(); check("lit_jump_en", imem_en, 0);
    to_pos(); jump_flag = 1'b0;
    to_neg(); check("lit_j1_valid", instr_valid, 0); check("lit_j1_addr", imem_addr, 16'h0040);
    to_pos(); to_neg(); check("lit_j2_addr", imem_addr, 16'h0041);
    to_pos(); to_neg();
    check("lit_j3_valid", instr_valid, 1);
    check("lit_j3_pc", instr_pc, 16'h0040);
    check("lit_j3_instr", instr, 16'h1040);
    to_pos(); to_neg();

    // back-to-back jumps
    to_pos(); jump_flag = 1'b1; jump_addr = 16'h0010; to_neg();
    to_pos(); jump_addr = 16'h0020;
    to_neg(); check("lit_bb_en", imem_en, 0); check("lit_bb_valid", instr_valid, 0);
    to_pos(); jump_flag = 1'b0;
    to_neg(); check("lit_bb_addr", imem_addr, 16'h0020);
    to_pos(); to_pos();
    to_neg(); check("lit_bb_pc", instr_pc, 16'h0020); check("lit_bb_instr", instr, 16'h1020);
    to_pos(); to_neg(); check("lit_bb_pc2", instr_pc, 16'h0021);

    // fill the FIFO, then halt and drain, jump during halt
    to_pos(); instr_ready = 1'b0;
    to_pos(); to_pos();
    to_neg(); check("lit_full_en", imem_en, 0); check("lit_full_pc", instr_pc, 16'h0022);
    to_pos(); halt = 1'b1; instr_ready = 1'b1;
    to_neg(); check("lit_halt_en", imem_en, 0); check("lit_halt_pc", instr_pc, 16'h0022);
    to_pos(); to_neg(); check("lit_drain_pc", instr_pc, 16'h0023);
    to_pos(); jump_flag = 1'b1; jump_addr = 16'h0080;
    to_neg(); check("lit_drained_valid", instr_valid, 0); check("lit_hj_en", imem_en, 0);
    to_pos(); jump_flag = 1'b0;
    to_neg(); check("lit_halt2_en", imem_en, 0);
    to_pos(); halt = 1'b0;
    to_neg(); check("lit_unhalt_en", imem_en, 1); check("lit_unhalt_addr", imem_addr, 16'h0080);
    to_pos(); to_pos();
    to_neg(); check("lit_unhalt_pc", instr_pc, 16'h0080);

    // reset mid-stream
    repeat (3) to_pos();
    rst_n = 1'b0;
    #1;
    check("lit_mrst_valid", instr_valid, 0);
    check("lit_mrst_instr", instr, 0);
    check("lit_mrst_pc", instr_pc, 0);
    check("lit_mrst_en", imem_en, 0);
    to_pos(); to_pos(); rst_n = 1'b1;
    to_neg(); check("lit_rst2_addr", imem_addr, 16'h0000); check("lit_rst2_en", imem_en, 1);
    to_pos(); to_pos();
    to_neg(); check("lit_rst2_pc", instr_pc, 16'h0000); check("lit_rst2_instr", instr, 16'h1000);
    repeat (3) to_pos();

    // wrap-around instance
    check("wrap_count", cap_pc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (cap_pc.size() > i) begin
        check($sformatf("wrap_pc%0d", i), cap_pc[i], exp_pc1[i]);
        check($sformatf("wrap_instr%0d", i), cap_d[i], exp_d1[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
